// File: rtl/eth_rx_deframer_pkg.sv
// Shared definitions for the Ethernet receive deframer: wire constants, CRC-32
// parameters, error-bit indices, FSM encoding and the byte-wide CRC step.
package eth_rx_deframer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int unsigned ERR_FCS       = 0;
    localparam int unsigned ERR_LEN       = 1;
    localparam int unsigned ERR_FRAMING   = 2;

    // Number of trailing bytes held back so the FCS is never forwarded.
    localparam int unsigned DLINE_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    // Reflected CRC-32, one byte consumed LSB first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-wide CRC-32 register: synchronous clear to the init value, update when enabled.
// Shared by the receive checker and the transmit FCS generator.
module eth_crc32_byte
    import eth_rx_deframer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_next(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_rx_deframer.sv
// Ethernet receive deframer: checks/strips preamble and SFD, forwards payload through
// a 4-byte delay line so the FCS is withheld, and reports per-frame status.
module eth_rx_deframer
    import eth_rx_deframer_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 64,
    parameter int unsigned MAX_FRAME    = 1518
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_rxen,
    input  logic [7:0] in_rxd,
    output logic       out_dll_rxen,
    output logic [7:0] out_dll_rxd,
    output logic       out_frame_done,
    output logic       out_frame_ok,
    output logic [2:0] out_err
);

    localparam int unsigned PCW = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned BCW = 11;

    localparam logic [PCW-1:0] PREAMBLE_MAX = PCW'(PREAMBLE_LEN);
    localparam logic [BCW-1:0] MIN_CNT      = BCW'(MIN_FRAME);
    localparam logic [BCW-1:0] OVERSIZE_CNT = BCW'(MAX_FRAME + 1);
    localparam logic [BCW-1:0] FWD_CNT      = BCW'(DLINE_DEPTH);
    localparam logic [BCW-1:0] BCOUNT_SAT   = '1;

    rx_state_e                     state_q, state_d;
    logic [PCW-1:0]                pcount_q, pcount_d;
    logic [BCW-1:0]                bcount_q, bcount_d, bcount_inc;
    logic [2:0]                    err_q, err_d;
    logic [DLINE_DEPTH-1:0][7:0]   dline_q;
    logic                          dline_shift;

    logic                          crc_clear, crc_en;
    logic [31:0]                   crc;

    logic                          dll_rxen_d;
    logic [7:0]                    dll_rxd_d;
    logic                          done_d, ok_d;
    logic [2:0]                    out_err_d;

    eth_crc32_byte u_crc (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .data_i  (in_rxd),
        .crc_o   (crc)
    );

    assign bcount_inc = (bcount_q == BCOUNT_SAT) ? bcount_q : bcount_q + BCW'(1);

    // NOTE: every signal driven here gets a default before the case statement, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pcount_d    = pcount_q;
        bcount_d    = bcount_q;
        err_d       = err_q;
        dline_shift = 1'b0;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;
        dll_rxen_d  = 1'b0;
        dll_rxd_d   = 8'h00;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        out_err_d   = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (in_rxen) begin
                    err_d = 3'b000;
                    if (in_rxd == PREAMBLE_BYTE) begin
                        state_d  = ST_PREAMBLE;
                        pcount_d = PCW'(1);
                    end else begin
                        state_d            = ST_DROP;
                        err_d[ERR_FRAMING] = 1'b1;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!in_rxen) begin
                    state_d                = ST_IDLE;
                    done_d                 = 1'b1;
                    out_err_d[ERR_FRAMING] = 1'b1;
                end else if (in_rxd == SFD_BYTE) begin
                    state_d   = ST_PAYLOAD;
                    crc_clear = 1'b1;
                    bcount_d  = '0;
                end else if (in_rxd == PREAMBLE_BYTE && pcount_q < PREAMBLE_MAX) begin
                    pcount_d = pcount_q + PCW'(1);
                end else begin
                    state_d            = ST_DROP;
                    err_d[ERR_FRAMING] = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (!in_rxen) begin
                    state_d            = ST_IDLE;
                    done_d             = 1'b1;
                    out_err_d[ERR_FCS] = (crc != CRC_RESIDUE);
                    out_err_d[ERR_LEN] = (bcount_q < MIN_CNT);
                    ok_d               = (out_err_d == 3'b000);
                end else begin
                    crc_en      = 1'b1;
                    dline_shift = 1'b1;
                    bcount_d    = bcount_inc;
                    if (bcount_inc == OVERSIZE_CNT) begin
                        state_d        = ST_DROP;
                        err_d[ERR_LEN] = 1'b1;
                    end else if (bcount_q >= FWD_CNT) begin
                        dll_rxen_d = 1'b1;
                        dll_rxd_d  = dline_q[DLINE_DEPTH-1];
                    end
                end
            end

            ST_DROP: begin
                // An oversize frame keeps its CRC running so the FCS verdict still reflects the whole frame.
                if (in_rxen) begin
                    crc_en = err_q[ERR_LEN];
                end else begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    out_err_d = err_q;
                    if (err_q[ERR_LEN]) begin
                        out_err_d[ERR_FCS] = (crc != CRC_RESIDUE);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the delay line is only four bytes, so it is reset along with the other
    // state; larger buffers would normally be left unreset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pcount_q       <= '0;
            bcount_q       <= '0;
            err_q          <= 3'b000;
            dline_q        <= '0;
            out_dll_rxen   <= 1'b0;
            out_dll_rxd    <= 8'h00;
            out_frame_done <= 1'b0;
            out_frame_ok   <= 1'b0;
            out_err        <= 3'b000;
        end else begin
            state_q        <= state_d;
            pcount_q       <= pcount_d;
            bcount_q       <= bcount_d;
            err_q          <= err_d;
            if (dline_shift) begin
                dline_q <= {dline_q[DLINE_DEPTH-2:0], in_rxd};
            end
            out_dll_rxen   <= dll_rxen_d;
            out_dll_rxd    <= dll_rxd_d;
            out_frame_done <= done_d;
            out_frame_ok   <= ok_d;
            out_err        <= out_err_d;
        end
    end

endmodule
